param_fifo: RTL and testbench

Parametrised single-clock FIFO, the successor to the team's fixed 8-bit FIFO. Generalises data width and depth, adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in one clock domain, as a drop-in for the old FIFO with the extra status outputs left unconnected.

---
 rtl/param_fifo.sv | 117 +++++++++++
 tb/tb_param_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo -- parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, overflow/underflow pulses
// and an optional first-word-fall-through read mode.
//
// Parameters
//   DATA_WIDTH        word width in bits (>= 1)
//   DEPTH             number of entries, power of two, >= 2
//   ALMOST_FULL_THR   almost_full  when count >= this value (1..DEPTH)
//   ALMOST_EMPTY_THR  almost_empty when count <= this value (0..DEPTH-1)
//   FWFT              0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   reset         in   asynchronous active-low reset, synchronous release
//   w_en          in   write request
//   r_en          in   read request
//   data_in       in   write data, sampled with w_en
//   data_out      out  read data
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= ALMOST_FULL_THR
//   almost_empty  out  count <= ALMOST_EMPTY_THR
//   count         out  current occupancy, 0..DEPTH
//   overflow      out  one-cycle pulse after a rejected write
//   underflow     out  one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module param_fifo #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH            = 8,
    parameter int ALMOST_FULL_THR  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THR = 1,
    parameter int FWFT             = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Thresholds sized to the count width so the compares are width-matched.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THR  = CW'(ALMOST_FULL_THR);
    localparam logic [CW-1:0] AE_THR  = CW'(ALMOST_EMPTY_THR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags are pure decodes of the registered count, so they cannot glitch
    // between edges and clear immediately on an asynchronous reset.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    // Acceptance looks only at the flags present at this edge: a write into a
    // full FIFO is rejected even if a read frees a slot on the same edge.
    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= w_en & full;
            underflow <= r_en & empty;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; r_en pops it.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            // Holds its value across idle cycles and rejected reads.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)      dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo -- directed self-checking bench for param_fifo.
// dut0 runs in registered-read mode, dut1 in first-word-fall-through mode;
// both use DATA_WIDTH=8, DEPTH=8, ALMOST_FULL_THR=6, ALMOST_EMPTY_THR=1.
// Inputs change 1 ns after a rising edge and outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic       w0, r0, w1, r1;
    logic [7:0] din0, din1;
    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ov0, uf0;
    logic       full1, empty1, af1, ae1, ov1, uf1;
    logic [3:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ALMOST_FULL_THR(6),
                 .ALMOST_EMPTY_THR(1), .FWFT(0)) dut0 (
        .clk(clk), .reset(rst0), .w_en(w0), .r_en(r0), .data_in(din0),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(uf0));

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ALMOST_FULL_THR(6),
                 .ALMOST_EMPTY_THR(1), .FWFT(1)) dut1 (
        .clk(clk), .reset(rst1), .w_en(w1), .r_en(r1), .data_in(din1),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(uf1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        w0 = 1'b0; r0 = 1'b0; w1 = 1'b0; r1 = 1'b0;
        din0 = 8'h00; din1 = 8'h00;

        // ---------------- reset ----------------
        step(); step();
        rst0 = 1'b1; rst1 = 1'b1;
        step();
        check("rst_empty",  32'(empty0), 1);
        check("rst_ae",     32'(ae0),    1);
        check("rst_full",   32'(full0),  0);
        check("rst_af",     32'(af0),    0);
        check("rst_count",  32'(cnt0),   0);
        check("rst_dout",   32'(dout0),  0);
        check("rst_ov",     32'(ov0),    0);
        check("rst_uf",     32'(uf0),    0);
        check("rst_dout_f", 32'(dout1),  0);
        check("rst_empty_f",32'(empty1), 1);

        // ---------------- fill and overflow ----------------
        w0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din0 = 8'h11 + 8'(i);
            step();
            check("fill_count", 32'(cnt0),  i + 1);
            check("fill_ae",    32'(ae0),   (i + 1 <= 1) ? 1 : 0);
            check("fill_af",    32'(af0),   (i + 1 >= 6) ? 1 : 0);
            check("fill_full",  32'(full0), (i == 7) ? 1 : 0);
            check("fill_empty", 32'(empty0), 0);
        end
        din0 = 8'h40;
        step();
        check("ovf_pulse", 32'(ov0),  1);
        check("ovf_count", 32'(cnt0), 8);
        w0 = 1'b0;
        step();
        check("ovf_clear", 32'(ov0),  0);
        check("ovf_count2",32'(cnt0), 8);

        // ---------------- drain and underflow ----------------
        r0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_data",  32'(dout0), 8'h11 + 8'(i));
            check("drain_count", 32'(cnt0),  7 - i);
        end
        check("drain_empty", 32'(empty0), 1);
        check("drain_ae",    32'(ae0),    1);
        step();
        check("udf_pulse", 32'(uf0),   1);
        check("udf_hold",  32'(dout0), 8'h18);
        r0 = 1'b0;
        step();
        check("udf_clear", 32'(uf0),   0);
        check("udf_hold2", 32'(dout0), 8'h18);

        // ---------------- simultaneous at count=4 ----------------
        w0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din0 = 8'h31 + 8'(i);
            step();
        end
        check("mid_count", 32'(cnt0), 4);
        r0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din0 = 8'h35 + 8'(i);
            step();
            check("rw_count", 32'(cnt0),  4);
            check("rw_data",  32'(dout0), 8'h31 + 8'(i));
        end
        w0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rw_tail", 32'(dout0), 8'h34 + 8'(i));
        end
        r0 = 1'b0;
        check("rw_empty", 32'(empty0), 1);

        // ---------------- simultaneous at full ----------------
        w0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din0 = 8'h50 + 8'(i);
            step();
        end
        check("full_again", 32'(full0), 1);
        r0 = 1'b1; din0 = 8'h99;
        step();
        check("rwf_count", 32'(cnt0),  7);
        check("rwf_ov",    32'(ov0),   1);
        check("rwf_data",  32'(dout0), 8'h50);
        w0 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("rwf_drain", 32'(dout0), 8'h51 + 8'(i));
        end
        check("rwf_empty", 32'(empty0), 1);

        // ---------------- simultaneous at empty (r0 still high) ----------------
        w0 = 1'b1; din0 = 8'h66;
        step();
        check("rwe_count", 32'(cnt0),  1);
        check("rwe_uf",    32'(uf0),   1);
        check("rwe_hold",  32'(dout0), 8'h57);
        w0 = 1'b0;
        step();
        r0 = 1'b0;
        check("rwe_data",  32'(dout0), 8'h66);
        check("rwe_empty", 32'(cnt0),  0);

        // ---------------- wrap-around ----------------
        w0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din0 = 8'hE0 + 8'(i);
            step();
        end
        w0 = 1'b0; r0 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("wrap_pre", 32'(dout0), 8'hE4);
        r0 = 1'b0; w0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din0 = 8'h21 + 8'(i);
            step();
        end
        w0 = 1'b0;
        check("wrap_full",  32'(full0), 1);
        check("wrap_count", 32'(cnt0),  8);
        r0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("wrap_data", 32'(dout0), 8'h21 + 8'(i));
        end
        r0 = 1'b0;
        check("wrap_empty", 32'(empty0), 1);

        // ---------------- FWFT ----------------
        w1 = 1'b1; din1 = 8'hA5;
        step();
        w1 = 1'b0;
        check("fwft_empty", 32'(empty1), 0);
        check("fwft_data",  32'(dout1),  8'hA5);
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        check("fwft_pop_empty", 32'(empty1), 1);
        check("fwft_pop_data",  32'(dout1),  0);
        w1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din1 = 8'hB1 + 8'(i);
            step();
        end
        w1 = 1'b0;
        check("fwft_count3", 32'(cnt1),  3);
        check("fwft_head",   32'(dout1), 8'hB1);

        // ---------------- asynchronous mid-operation reset ----------------
        #2;
        rst1 = 1'b0;
        #1;
        check("arst_count", 32'(cnt1),   0);
        check("arst_empty", 32'(empty1), 1);
        check("arst_dout",  32'(dout1),  0);
        step();
        rst1 = 1'b1;
        w1 = 1'b1; din1 = 8'hC7;
        step();
        w1 = 1'b0;
        check("post_rst_count", 32'(cnt1),  1);
        check("post_rst_data",  32'(dout1), 8'hC7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
